input_conditioner: RTL and testbench

Front-end conditioning stage between the board pins and the top-level keyboard controller. It synchronises, debounces and edge-detects every raw key, button and switch before the mode logic, piano, auto-play and learning controllers see it. It delivers clean levels for the note/octave keys and switches, plus single-cycle press pulses for `confirm`, `next` and `prev`. `next` and `prev` also auto-repeat while held, for fast song browsing.

---
 rtl/cosmic_input_pkg.sv | 23 ++
 rtl/debounce_channel.sv | 55 +++++
 rtl/input_conditioner.sv | 129 ++++++++++++
 tb/tb_input_conditioner.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cosmic_input_pkg.sv
// Shared constants and types for the keyboard input conditioning front end.
package cosmic_input_pkg;

    localparam int BTN_CONFIRM = 0;
    localparam int BTN_NEXT    = 1;
    localparam int BTN_PREV    = 2;
    localparam int SW_ADJ      = 3;

    localparam int DEF_DEBOUNCE_CYCLES = 2_000_000;
    localparam int DEF_HOLD_CYCLES     = 50_000_000;
    localparam int DEF_REPEAT_CYCLES   = 20_000_000;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } rep_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: two-flop synchroniser, stability counter, debounced level and press strobe.
module debounce_channel
    import cosmic_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic level_nxt,
    output logic rise_nxt
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    // Next-state values are exported so the top can register pulses aligned with level.
    always_comb begin
        level_nxt = level;
        rise_nxt  = 1'b0;
        cnt_nxt   = '0;
        if (s2 != level) begin
            if (cnt == CNT_LAST) begin
                level_nxt = s2;
                rise_nxt  = s2;
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            cnt   <= cnt_nxt;
            level <= level_nxt;
            rise  <= rise_nxt;
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Debounces all board inputs and generates confirm/next/prev press pulses with
// auto-repeat on next/prev; simultaneous next+prev is treated as no command.
module input_conditioner
    import cosmic_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] key_raw,
    input  logic [1:0] octave_raw,
    input  logic [2:0] btn_raw,
    input  logic [3:0] sw_raw,
    output logic [6:0] key_level,
    output logic [1:0] octave_level,
    output logic [3:0] sw_level,
    output logic [2:0] btn_level,
    output logic       confirm_pulse,
    output logic       next_pulse,
    output logic       prev_pulse
);

    localparam int NCH      = 16;
    localparam int BTN_BASE = 9;
    localparam int SW_BASE  = 12;
    localparam int RMAX     = max_int(HOLD_CYCLES, REPEAT_CYCLES);
    localparam int RW       = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

    logic [NCH-1:0] raw_all;
    logic [NCH-1:0] lvl;
    logic [NCH-1:0] rise;
    logic [NCH-1:0] lvl_nxt;
    logic [NCH-1:0] rise_nxt;

    assign raw_all = {sw_raw, btn_raw, octave_raw, key_raw};

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .raw      (raw_all[g]),
            .level    (lvl[g]),
            .rise     (rise[g]),
            .level_nxt(lvl_nxt[g]),
            .rise_nxt (rise_nxt[g])
        );
    end

    assign key_level     = lvl[6:0];
    assign octave_level  = lvl[8:7];
    assign btn_level     = lvl[BTN_BASE+2:BTN_BASE];
    assign sw_level      = {lvl[SW_BASE+SW_ADJ], lvl[SW_BASE+2:SW_BASE]};
    assign confirm_pulse = rise[BTN_BASE+BTN_CONFIRM];

    logic unused_ok;
    assign unused_ok = ^{rise, rise_nxt, lvl_nxt};

    // Index 0 = next, 1 = prev. Decisions use next-cycle levels so pulses line up with level.
    logic [1:0]    b_lvl;
    logic [1:0]    b_rise;
    logic          conflict;
    rep_state_t    state [2];
    logic [RW-1:0] rcnt  [2];
    logic [1:0]    rep_pulse;

    assign b_lvl    = {lvl_nxt[BTN_BASE+BTN_PREV], lvl_nxt[BTN_BASE+BTN_NEXT]};
    assign b_rise   = {rise_nxt[BTN_BASE+BTN_PREV], rise_nxt[BTN_BASE+BTN_NEXT]};
    assign conflict = b_lvl[0] & b_lvl[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                state[i] <= IDLE;
                rcnt[i]  <= '0;
            end
            rep_pulse <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                rep_pulse[i] <= 1'b0;
                if (conflict) begin
                    state[i] <= IDLE;
                    rcnt[i]  <= '0;
                end else begin
                    case (state[i])
                        IDLE: begin
                            if (b_rise[i]) begin
                                rep_pulse[i] <= 1'b1;
                                state[i]     <= HOLD;
                                rcnt[i]      <= '0;
                            end
                        end
                        HOLD: begin
                            if (!b_lvl[i]) begin
                                state[i] <= IDLE;
                            end else if (rcnt[i] == HOLD_LAST) begin
                                rep_pulse[i] <= 1'b1;
                                state[i]     <= REPEAT;
                                rcnt[i]      <= '0;
                            end else begin
                                rcnt[i] <= rcnt[i] + RW'(1);
                            end
                        end
                        REPEAT: begin
                            if (!b_lvl[i]) begin
                                state[i] <= IDLE;
                            end else if (rcnt[i] == REP_LAST) begin
                                rep_pulse[i] <= 1'b1;
                                rcnt[i]      <= '0;
                            end else begin
                                rcnt[i] <= rcnt[i] + RW'(1);
                            end
                        end
                        default: state[i] <= IDLE;
                    endcase
                end
            end
        end
    end

    assign next_pulse = rep_pulse[0];
    assign prev_pulse = rep_pulse[1];

endmodule

// File: tb/tb_input_conditioner.sv
// Directed-vector bench for input_conditioner with short debounce/hold/repeat times.
module tb_input_conditioner;

    logic       clk;
    logic       reset;
    logic [6:0] key_raw;
    logic [1:0] octave_raw;
    logic [2:0] btn_raw;
    logic [3:0] sw_raw;
    logic [6:0] key_level;
    logic [1:0] octave_level;
    logic [3:0] sw_level;
    logic [2:0] btn_level;
    logic       confirm_pulse;
    logic       next_pulse;
    logic       prev_pulse;

    int vectors = 0;
    int miscompares = 0;

    input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (20),
        .REPEAT_CYCLES  (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_raw      (key_raw),
        .octave_raw   (octave_raw),
        .btn_raw      (btn_raw),
        .sw_raw       (sw_raw),
        .key_level    (key_level),
        .octave_level (octave_level),
        .sw_level     (sw_level),
        .btn_level    (btn_level),
        .confirm_pulse(confirm_pulse),
        .next_pulse   (next_pulse),
        .prev_pulse   (prev_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int np;
        reset = 1'b0;
        key_raw = '1; octave_raw = '1; btn_raw = '1; sw_raw = '1;
        repeat (3) tick();
        vectors++;
        if ({key_level, octave_level, sw_level, btn_level, confirm_pulse, next_pulse, prev_pulse} !== 19'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %0h expected 0",
                     {key_level, octave_level, sw_level, btn_level, confirm_pulse, next_pulse, prev_pulse});
        end
        reset = 1'b1;
        repeat (5) tick();
        vectors++;
        if (key_level !== 7'h00) begin
            miscompares++;
            $display("FAIL reset_latency_early: key_level %0h expected 00", key_level);
        end
        tick();
        vectors++;
        if (key_level !== 7'h7F) begin
            miscompares++;
            $display("FAIL reset_release_keys: key_level %0h expected 7f", key_level);
        end
        vectors++;
        if ({btn_level, octave_level, sw_level} !== 9'h1FF) begin
            miscompares++;
            $display("FAIL reset_release_other: got %0h expected 1ff", {btn_level, octave_level, sw_level});
        end
        vectors++;
        if ({confirm_pulse, next_pulse, prev_pulse} !== 3'b100) begin
            miscompares++;
            $display("FAIL reset_release_pulses: got %b expected 100", {confirm_pulse, next_pulse, prev_pulse});
        end
        tick();
        vectors++;
        if (confirm_pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_confirm_width: got %b expected 0", confirm_pulse);
        end
        np = 0;
        key_raw = '0; octave_raw = '0; btn_raw = '0; sw_raw = '0;
        for (int k = 0; k < 14; k++) begin
            tick();
            np += int'(next_pulse) + int'(prev_pulse) + int'(confirm_pulse);
        end
        vectors++;
        if (np != 0 || {key_level, btn_level, octave_level, sw_level} !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_all_release: pulses %0d levels %0h expected 0 and 0",
                     np, {key_level, btn_level, octave_level, sw_level});
        end
    endtask

    task automatic test_glitch();
        int seen;
        key_raw[3] = 1'b1;
        repeat (3) tick();
        key_raw[3] = 1'b0;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (key_level[3]) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL glitch_3cyc: level high %0d cycles expected 0", seen);
        end
        key_raw[3] = 1'b1;
        repeat (5) tick();
        vectors++;
        if (key_level[3] !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch_rise_early: got %b expected 0", key_level[3]);
        end
        tick();
        vectors++;
        if (key_level[3] !== 1'b1) begin
            miscompares++;
            $display("FAIL glitch_rise_edge6: got %b expected 1", key_level[3]);
        end
        repeat (4) tick();
        key_raw[3] = 1'b0;
        repeat (5) tick();
        vectors++;
        if (key_level[3] !== 1'b1) begin
            miscompares++;
            $display("FAIL glitch_fall_early: got %b expected 1", key_level[3]);
        end
        tick();
        vectors++;
        if (key_level[3] !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch_fall_edge6: got %b expected 0", key_level[3]);
        end
    endtask

    task automatic test_confirm();
        int n_press, n_rel, at;
        n_press = 0; n_rel = 0; at = -1;
        btn_raw[0] = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (confirm_pulse) begin
                n_press++;
                at = k;
            end
        end
        btn_raw[0] = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (confirm_pulse) n_rel++;
        end
        vectors++;
        if (n_press != 1 || at != 6) begin
            miscompares++;
            $display("FAIL confirm_press: count %0d at %0d expected 1 at 6", n_press, at);
        end
        vectors++;
        if (n_rel != 0 || btn_level[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL confirm_release: count %0d level %b expected 0 and 0", n_rel, btn_level[0]);
        end
    endtask

    task automatic test_auto_repeat();
        int offs[$];
        int exp_offs[6] = '{0, 20, 28, 36, 44, 52};
        int n_prev;
        n_prev = 0;
        btn_raw[1] = 1'b1;
        for (int k = 0; k < 12 && !btn_level[1]; k++) tick();
        vectors++;
        if (btn_level[1] !== 1'b1 || next_pulse !== 1'b1) begin
            miscompares++;
            $display("FAIL repeat_first: level %b pulse %b expected 1 and 1", btn_level[1], next_pulse);
        end
        offs.push_back(0);
        for (int k = 1; k <= 70; k++) begin
            if (k == 51) btn_raw[1] = 1'b0;
            tick();
            if (next_pulse) offs.push_back(k);
            if (prev_pulse) n_prev++;
        end
        vectors++;
        if (offs.size() != 6 || n_prev != 0) begin
            miscompares++;
            $display("FAIL repeat_count: next pulses %0d prev pulses %0d expected 6 and 0", offs.size(), n_prev);
        end
        for (int i = 0; i < 6 && i < offs.size(); i++) begin
            vectors++;
            if (offs[i] != exp_offs[i]) begin
                miscompares++;
                $display("FAIL repeat_time_%0d: offset %0d expected %0d", i, offs[i], exp_offs[i]);
            end
        end
    endtask

    task automatic test_conflict();
        int nn, np, at;
        nn = 0; np = 0; at = -1;
        btn_raw[1] = 1'b1;
        for (int k = 0; k < 12 && !btn_level[1]; k++) tick();
        vectors++;
        if (next_pulse !== 1'b1) begin
            miscompares++;
            $display("FAIL conflict_next_first: got %b expected 1", next_pulse);
        end
        repeat (10) tick();
        btn_raw[2] = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            nn += int'(next_pulse);
            np += int'(prev_pulse);
        end
        vectors++;
        if (nn != 0 || np != 0 || btn_level[2:1] !== 2'b11) begin
            miscompares++;
            $display("FAIL conflict_both_held: next %0d prev %0d levels %b expected 0 0 11", nn, np, btn_level[2:1]);
        end
        btn_raw[2] = 1'b0;
        nn = 0;
        for (int k = 0; k < 35; k++) begin
            tick();
            nn += int'(next_pulse);
        end
        vectors++;
        if (nn != 0) begin
            miscompares++;
            $display("FAIL conflict_no_repulse: next pulses %0d expected 0", nn);
        end
        btn_raw[1] = 1'b0;
        repeat (10) tick();
        np = 0;
        btn_raw[2] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (prev_pulse) begin
                np++;
                at = k;
            end
        end
        btn_raw[2] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            np += int'(prev_pulse);
        end
        vectors++;
        if (np != 1 || at != 6) begin
            miscompares++;
            $display("FAIL conflict_prev_alone: count %0d at %0d expected 1 at 6", np, at);
        end
    endtask

    task automatic test_reset_mid();
        btn_raw[1] = 1'b1;
        for (int k = 0; k < 12 && !btn_level[1]; k++) tick();
        repeat (27) tick();
        reset = 1'b0;
        #1;
        vectors++;
        if ({key_level, octave_level, sw_level, btn_level, confirm_pulse, next_pulse, prev_pulse} !== 19'h0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got %0h expected 0",
                     {key_level, octave_level, sw_level, btn_level, confirm_pulse, next_pulse, prev_pulse});
        end
        tick();
        vectors++;
        if (next_pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_no_pulse: got %b expected 0", next_pulse);
        end
        btn_raw[1] = 1'b0;
        reset = 1'b1;
        repeat (10) tick();
        vectors++;
        if ({btn_level, next_pulse} !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_mid_after: got %0h expected 0", {btn_level, next_pulse});
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_confirm();
        test_auto_repeat();
        test_conflict();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
